// File: rtl/bpu_update_gen_pkg.sv
// Shared BPU types used by the back-end update generator: prediction record,
// predictor update record, branch-type codes and the generator's FSM states.
package bpu_update_gen_pkg;

  localparam int BPU_LPHT_ADDR_WIDTH = 8;

  localparam logic [1:0] BR_OTHER       = 2'b00;
  localparam logic [1:0] BR_PC_RELATIVE = 2'b01;
  localparam logic [1:0] BR_CALL        = 2'b10;
  localparam logic [1:0] BR_RETURN      = 2'b11;

  typedef struct packed {
    logic                           taken;
    logic [29:0]                    npc;
    logic [1:0]                     lphr;
    logic [BPU_LPHT_ADDR_WIDTH-1:0] lphr_index;
    logic [1:0]                     fsc;
  } bpu_predict_t;

  typedef struct packed {
    logic                           flush;
    logic [29:0]                    pc;
    logic [31:0]                    br_target;
    logic [1:0]                     br_type;
    logic                           br_taken;
    logic                           btb_update;
    logic                           lpht_update;
    logic [1:0]                     lphr;
    logic [BPU_LPHT_ADDR_WIDTH-1:0] lphr_index;
  } bpu_update_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } upd_state_e;

endpackage

// File: rtl/bpu_update_gen_if.sv
// Bundle between execute/back end and the update generator.
// slave is the generator side, master is the execute/back-end side.
interface bpu_update_gen_if;
  import bpu_update_gen_pkg::*;

  logic         res_valid_i;
  logic         res_ready_o;
  logic [29:0]  res_pc_i;
  logic         res_is_branch_i;
  logic [1:0]   res_br_type_i;
  logic         res_taken_i;
  logic [31:0]  res_target_i;
  bpu_predict_t res_pred_i;
  logic         front_flush_i;
  logic         kill_ack_i;
  bpu_update_t  update_o;
  logic         mispredict_o;

  modport slave (
    input  res_valid_i, res_pc_i, res_is_branch_i, res_br_type_i,
           res_taken_i, res_target_i, res_pred_i, front_flush_i, kill_ack_i,
    output res_ready_o, update_o, mispredict_o
  );

  modport master (
    output res_valid_i, res_pc_i, res_is_branch_i, res_br_type_i,
           res_taken_i, res_target_i, res_pred_i, front_flush_i, kill_ack_i,
    input  res_ready_o, update_o, mispredict_o
  );

endinterface

// File: rtl/bpu_update_gen_upd_fifo.sv
// Small synchronous FIFO of training updates with head peek.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module upd_fifo
  import bpu_update_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  bpu_update_t push_data,
  input  logic        pop,
  output bpu_update_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bpu_update_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Advance pointers; pushes into a full FIFO and pops from an empty one are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bpu_update_gen.sv
// Back-end update generator: turns resolved branches into predictor updates,
// issuing a one-cycle redirect flush on mispredict and queueing training
// updates that are retried while the front end's flush has priority.
module bpu_update_gen
  import bpu_update_gen_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 4,
  parameter int LPHT_ADDR_WIDTH = BPU_LPHT_ADDR_WIDTH
) (
  input logic              clk,
  input logic              rst,
  bpu_update_gen_if.slave  bus
);

  upd_state_e  state_q;
  upd_state_e  state_d;
  logic [29:0] anpc;
  logic        mis;
  logic        btb_upd;
  logic        lpht_upd;
  logic        ready;
  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [LPHT_ADDR_WIDTH-1:0] lphr_index;
  bpu_update_t train;
  bpu_update_t head;
  bpu_update_t flush_q;

  assign lphr_index = bus.res_pred_i.lphr_index;

  // Resolve the actual next PC, detect a mispredict and build the training record.
  always_comb begin
    anpc     = bus.res_taken_i ? bus.res_target_i[31:2] : bus.res_pc_i + 30'd1;
    mis      = bus.res_is_branch_i &
               ((bus.res_taken_i != bus.res_pred_i.taken) | (anpc != bus.res_pred_i.npc));
    btb_upd  = bus.res_is_branch_i & bus.res_taken_i & mis;
    lpht_upd = bus.res_is_branch_i & (bus.res_br_type_i == BR_PC_RELATIVE);

    train             = '0;
    train.flush       = 1'b0;
    train.pc          = bus.res_pc_i;
    train.br_target   = bus.res_target_i;
    train.br_type     = bus.res_br_type_i;
    train.br_taken    = bus.res_taken_i;
    train.btb_update  = btb_upd;
    train.lpht_update = lpht_upd;
    train.lphr        = bus.res_pred_i.lphr;
    train.lphr_index  = lphr_index;
  end

  // Next-state and ready: RUN accepts when the queue has room, FLUSH blocks for
  // the single redirect cycle, DRAIN swallows wrong-path records until kill ack.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      RUN: begin
        ready = ~fifo_full;
        if (bus.res_valid_i && ready && mis) state_d = FLUSH;
      end
      FLUSH: begin
        ready   = 1'b0;
        state_d = bus.kill_ack_i ? RUN : DRAIN;
      end
      DRAIN: begin
        ready = 1'b1;
        if (bus.kill_ack_i) state_d = RUN;
      end
      default: begin
        ready   = 1'b0;
        state_d = RUN;
      end
    endcase
    ready = ready & ~rst;
  end

  assign accept    = bus.res_valid_i & ready;
  assign fifo_push = (state_q == RUN) & accept & ~mis & (btb_upd | lpht_upd);
  assign fifo_pop  = (state_q != FLUSH) & ~fifo_empty & ~bus.front_flush_i;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Capture the redirect update; its target is the corrected next PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
    end else if ((state_q == RUN) && accept && mis) begin
      flush_q           <= train;
      flush_q.flush     <= 1'b1;
      flush_q.br_target <= {anpc, 2'b00};
    end
  end

  upd_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (train),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output mux: redirect during FLUSH, otherwise the queue head or nothing.
  always_comb begin
    bus.update_o     = '0;
    bus.mispredict_o = 1'b0;
    if (state_q == FLUSH) begin
      bus.update_o     = flush_q;
      bus.mispredict_o = 1'b1;
    end else if (!fifo_empty) begin
      bus.update_o       = head;
      bus.update_o.flush = 1'b0;
    end
  end

  assign bus.res_ready_o = ready;

endmodule

// File: doc/bpu_update_gen.md
# bpu_update_gen

- Back-end producer of the `bpu_update_t` stream that the branch predictor consumes on its back-end update port.
- Accepts resolved branch records from execute over a valid/ready handshake and compares each against the prediction carried with it.
- On a mispredict it issues a one-cycle redirect flush with training data attached. Otherwise it queues training-only updates and re-presents any that the predictor drops because a front-end flush took priority that cycle.
- After a redirect, it discards wrong-path resolutions until the back end acknowledges the kill.

## Interface
Parameters:
- `QUEUE_DEPTH`, default 4, training-update FIFO entries; power of two, ≥2.
- `LPHT_ADDR_WIDTH`, default `` `_LPHT_ADDR_WIDTH ``, width of `lphr_index`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `res_valid_i` in 1: resolved-branch record valid.
- `res_ready_o` out 1: record accepted on `res_valid_i & res_ready_o`.
- `res_pc_i` in 30: branch instruction PC[31:2].
- `res_is_branch_i` in 1: record is a control-transfer instruction.
- `res_br_type_i` in 2: actual branch type (`` `_PC_RELATIVE ``/`` `_CALL ``/`` `_RETURN ``/other).
- `res_taken_i` in 1: actual direction.
- `res_target_i` in 32: actual taken target.
- `res_pred_i` in `bpu_predict_t`: prediction carried down the pipe (`taken`, `npc`, `lphr`, `lphr_index`, `fsc`).
- `front_flush_i` in 1: front-end update has `flush=1` this cycle. When it is high, a non-flush `update_o` is dropped by the predictor.
- `kill_ack_i` in 1: back end has purged all ops younger than the mispredicted branch.
- `update_o` out `bpu_update_t`: registered update to the predictor's back-end port.
- `mispredict_o` out 1: one-cycle redirect pulse; equals `update_o.flush`.

## Operation
- Actual next PC: `anpc = res_taken_i ? res_target_i[31:2] : res_pc_i + 1`. Arithmetic is 30-bit and wraps.
- `mis = res_is_branch_i & (res_taken_i != res_pred_i.taken | anpc != res_pred_i.npc)`.
- Training fields are built from the accepted record:
  - `pc = res_pc_i`, `br_target = res_target_i`, `br_type = res_br_type_i`, `br_taken = res_taken_i`.
  - `lphr` and `lphr_index` are copied from `res_pred_i`. The counter update is the PHT's job, not this block's.
  - `btb_update = res_is_branch_i & res_taken_i & mis`.
  - `lpht_update = res_is_branch_i & res_br_type_i == `` `_PC_RELATIVE ``.
- A record with neither update bit set and `mis=0` is accepted and discarded.
- FSM states: `RUN`, `FLUSH`, `DRAIN`.
  - `RUN`: `res_ready_o = ~fifo_full`.
    - Accept with `mis=1`: load the flush register (training fields, `flush=1`, `br_target = {anpc,2'b00}`), then go to `FLUSH`. The record is not enqueued.
    - Accept with `mis=0` and an update bit set: push to the FIFO.
  - `FLUSH` (exactly 1 cycle): present the flush register on `update_o`; `mispredict_o=1`; `res_ready_o=0`; then go to `DRAIN`. If `kill_ack_i` is high in this cycle, go straight to `RUN`.
  - `DRAIN`: `res_ready_o=1`. Accepted records are discarded. Go to `RUN` on `kill_ack_i`.
- Output mux for cycles not in `FLUSH`:
  - FIFO non-empty: `update_o` = head with `flush=0`. Pop at edge iff `~front_flush_i`; otherwise hold the head for retry.
  - FIFO empty: `update_o` is all zeros.
- A back-end flush always wins in the predictor, so the flush update is never retried.
- Queued training entries survive a redirect: they belong to older, correct-path branches and drain after `FLUSH`.
- `fifo_full` is conservative. A same-cycle pop does not raise ready.

## Timing
- Accept at edge N:
  - Mispredict: `update_o.flush`/`mispredict_o` high for cycle N+1 only.
  - Training with an empty FIFO: appears in cycle N+1.
- FIFO order is strict FIFO. A retried head repeats unchanged every cycle until a cycle with `front_flush_i=0`.
- Reset (async assert, any state) produces:
  - State `RUN`, FIFO empty (queued contents lost).
  - `update_o` = 0, `mispredict_o` = 0.
  - `res_ready_o` = 0 while `rst` is high, 1 in the first cycle after deassert.
- `kill_ack_i` in `RUN` is ignored.

## Structure
- `bpu_update_t`, `bpu_predict_t`, the branch-type constants and `` `_LPHT_ADDR_WIDTH `` come from the shared BPU header/package. Nothing new is added there except the FSM state enum.
- One sub-module: `upd_fifo`, a parameterised synchronous FIFO of `bpu_update_t` with `full`/`empty`, push/pop and a head peek.

## Test plan
- Correct taken PC-relative branch (pc=0x1c000010>>2, pred.taken=1, npc=target=0x1c000100) → cycle N+1: `update_o` with `flush=0`, `lpht_update=1`, `btb_update=0`, `br_taken=1`; `mispredict_o=0`.
- Not-taken predicted taken (pc=0x1c000020) → N+1: `flush=1`, `br_target=0x1c000024`, `mispredict_o` one cycle. Three following records in `DRAIN` are discarded; `kill_ack_i` returns the FSM to `RUN`.
- Taken mispredict, target 0x1c001000 → `flush=1`, `btb_update=1`, `br_target=0x1c001000`.
- Training head present with `front_flush_i` high 2 cycles → same head repeated for 3 cycles; pop only in the 3rd.
- Fill FIFO with 4 entries while `front_flush_i` is stuck high → `res_ready_o=0`. Release → drains 4 entries in order over 4 cycles, then ready returns.
- Assert `rst` mid-`DRAIN` with 2 entries queued → `update_o`=0 immediately. After release, state is `RUN` and the FIFO is empty.
